fsm_fg_pulse_gen: RTL

//   Transmit side of the frame-grabber opto signal. Generates a programmable train of
//   fg_signal pulses (width, period, count) that drives the frame-grabber input and the

---
 rtl/fsm_fg_pulse_gen.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/fsm_fg_pulse_gen.sv
// Frame-grabber opto pulse generator: emits a programmable train of fg_signal pulses
// (width, period, count) and reports busy, done and the number of completed pulses.
module fsm_fg_pulse_gen #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] pulse_width,
  input  logic [CNT_W-1:0] pulse_period,
  input  logic [CNT_W-1:0] pulse_count,
  output logic             fg_signal,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulses_sent
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ALL_ONES = {CNT_W{1'b1}};

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [CNT_W-1:0] w_r, w_nxt_s;
  logic [CNT_W-1:0] low_r, low_nxt_s;
  logic [CNT_W-1:0] n_r, n_nxt_s;
  logic [CNT_W-1:0] pulses_r, pulses_nxt_s;
  logic [CNT_W-1:0] w_clamp_s, low_clamp_s;
  logic             fg_r, busy_r, done_r;

  // Clamp the requested shape so every pulse has at least one high and one low cycle;
  // the low time is stored directly, avoiding an overflow on W+1 when W is all-ones.
  always_comb begin
    w_clamp_s   = (pulse_width == ZERO) ? ONE : pulse_width;
    low_clamp_s = (pulse_period <= w_clamp_s) ? ONE : (pulse_period - w_clamp_s);
  end

  // Next-state and next-counter logic for the pulse train.
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    w_nxt_s      = w_r;
    low_nxt_s    = low_r;
    n_nxt_s      = n_r;
    pulses_nxt_s = pulses_r;
    case (state_r)
      ST_IDLE: begin
        if (start && !stop) begin
          state_nxt_s  = ST_HIGH;
          cnt_nxt_s    = ZERO;
          pulses_nxt_s = ZERO;
          w_nxt_s      = w_clamp_s;
          low_nxt_s    = low_clamp_s;
          n_nxt_s      = pulse_count;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_HIGH: begin
        if (stop) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = ZERO;
        end else if (cnt_r == (w_r - ONE)) begin
          state_nxt_s  = ST_LOW;
          cnt_nxt_s    = ZERO;
          pulses_nxt_s = (pulses_r == ALL_ONES) ? pulses_r : (pulses_r + ONE);
        end else begin
          cnt_nxt_s = cnt_r + ONE;
        end
      end
      ST_LOW: begin
        if (stop) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = ZERO;
        end else if (cnt_r == (low_r - ONE)) begin
          cnt_nxt_s = ZERO;
          if ((n_r != ZERO) && (pulses_r == n_r)) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_HIGH;
          end
        end else begin
          cnt_nxt_s = cnt_r + ONE;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = ZERO;
      end
    endcase
  end

  // State, configuration and counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= ZERO;
      w_r      <= ONE;
      low_r    <= ONE;
      n_r      <= ZERO;
      pulses_r <= ZERO;
    end else begin
      state_r  <= state_nxt_s;
      cnt_r    <= cnt_nxt_s;
      w_r      <= w_nxt_s;
      low_r    <= low_nxt_s;
      n_r      <= n_nxt_s;
      pulses_r <= pulses_nxt_s;
    end
  end

  // Outputs are registered from the next state so they line up with the state itself.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fg_r   <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      fg_r   <= (state_nxt_s == ST_HIGH);
      busy_r <= (state_nxt_s == ST_HIGH) || (state_nxt_s == ST_LOW);
      done_r <= (state_nxt_s == ST_DONE);
    end
  end

  assign fg_signal   = fg_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign pulses_sent = pulses_r;

endmodule
